// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: runs a WIDTH-bit add through one external CHUNK-bit
// adder, one chunk per cycle LSB first, with valid/ready on both ends.
module multiword_add_seq #(
  parameter int CHUNK  = 4,
  parameter int NCHUNK = 8,
  localparam int WIDTH = CHUNK * NCHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [CHUNK-1:0] add_a,
  output logic [CHUNK-1:0] add_b,
  output logic             add_cin,
  input  logic [CHUNK-1:0] add_sum,
  input  logic             add_cout
);

  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx;

  // NOTE: every state register, the operand copies included, is reset so a
  // mid-operation rst leaves no stale result visible on sum/cout/ovf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge value of idx/carry_q regardless of statement order.
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= cin;
            sum_q    <= '0;
            ovf      <= 1'b0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*CHUNK +: CHUNK] <= add_sum;
          carry_q                   <= add_cout;
          if (idx == LAST_IDX) begin
            // The last chunk holds the sign bit, so overflow is known now.
            ovf       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (add_sum[CHUNK-1] != a_q[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

  // Adder inputs sit at zero outside RUN so the shared adder does not toggle.
  // NOTE: defaults first in always_comb so no path leaves an output unassigned
  // and no latch is inferred.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_q[idx*CHUNK +: CHUNK];
      add_b   = b_q[idx*CHUNK +: CHUNK];
      add_cin = carry_q;
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: models the shared 4-bit adder, then checks results,
// latency, carry ripple, back-pressure, reset and throughput against plain arithmetic.
module tb_multiword_add_seq;

  localparam int CHUNK  = 4;
  localparam int NCHUNK = 8;
  localparam int WIDTH  = CHUNK * NCHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [CHUNK-1:0] add_a;
  logic [CHUNK-1:0] add_b;
  logic             add_cin;
  logic [CHUNK-1:0] add_sum;
  logic             add_cout;
  logic [CHUNK:0]   add_full;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  multiword_add_seq #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Shared combinational chunk adder living outside the DUT.
  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{CHUNK{1'b0}}, add_cin};
  assign add_sum  = add_full[CHUNK-1:0];
  assign add_cout = add_full[CHUNK];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Carry entering chunk k of a+b+c, from the integer sum of the lower bits.
  function automatic logic carry_into(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic c, input int k);
    logic [63:0] mask;
    logic [63:0] s;
    if (k == 0) return c;
    mask = (64'd1 << (CHUNK * k)) - 64'd1;
    s = (64'(x) & mask) + (64'(y) & mask) + 64'(c);
    return s[CHUNK * k];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_sum"}, 64'(sum), 64'd0);
    check({tag, "_cout"}, 64'(cout), 64'd0);
    check({tag, "_ovf"}, 64'(ovf), 64'd0);
    check({tag, "_add_in"}, {55'd0, add_a, add_b, add_cin}, 64'd0);
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // One full operation; hold = cycles out_ready stays low once out_valid is up.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic xc, input int hold, input bit keep_valid,
                       output int accept_cyc);
    logic [WIDTH:0]   ref_full;
    logic             ref_ovf;
    logic [WIDTH-1:0] held;
    int               k;
    ref_full = {1'b0, xa} + {1'b0, xb} + {{WIDTH{1'b0}}, xc};
    ref_ovf  = (xa[WIDTH-1] == xb[WIDTH-1]) && (ref_full[WIDTH-1] != xa[WIDTH-1]);
    out_ready = (hold == 0);
    wait_in_ready();
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    tick();
    accept_cyc = cyc;
    if (keep_valid) begin
      a = $urandom; b = $urandom; cin = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    k = 0;
    while (!out_valid && k < 40) begin
      if (k < NCHUNK) check({tag, "_add_cin"}, 64'(add_cin), 64'(carry_into(xa, xb, xc, k)));
      check({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
      tick();
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(NCHUNK));
    check({tag, "_sum"}, 64'(sum), 64'(ref_full[WIDTH-1:0]));
    check({tag, "_cout"}, 64'(cout), 64'(ref_full[WIDTH]));
    check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf));
    held = sum;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_sum"}, 64'(sum), 64'(held));
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_post_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_post_sum"}, 64'(sum), 64'(ref_full[WIDTH-1:0]));
  endtask

  initial begin
    int acc;
    int last_acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    #1;
    check_idle_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    do_op("ripple", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, acc);
    do_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, acc);
    do_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0, acc);
    do_op("bp", 32'h1234_5678, 32'h0000_0000, 1'b1, 5, 1'b0, acc);

    // Reset in the middle of chunk 3: asynchronous, no edge needed.
    wait_in_ready();
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("midrst_running", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_valid", 64'(out_valid), 64'd0);
    end
    rst = 1'b0;
    do_op("after_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, acc);

    // Back-to-back random traffic with in_valid never dropped.
    last_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      do_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 1'b1, acc);
      if (i > 0) check("rand_interval", 64'(acc - last_acc), 64'(NCHUNK + 2));
      last_acc = acc;
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
